// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// One transaction in flight; a watchdog completes a hung access with an error pattern.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  err
);

    localparam int BW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  r_if_ready;
    logic                  r_dm_ready;
    logic                  r_err;
    logic [BW-1:0]         r_burst_cnt;
    logic [TW-1:0]         r_tmo_cnt;

    logic                  w_grant;
    logic                  w_grant_dm;
    logic                  w_timeout;

    assign w_timeout = (TIMEOUT != 0) && (r_tmo_cnt == TW'(TIMEOUT - 1));

    // Grant selection: data has priority until it has starved fetch for a full burst.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_dm = 1'b0;
        if (r_state == IDLE) begin
            if (dm_req && if_req) begin
                w_grant    = 1'b1;
                w_grant_dm = (r_burst_cnt != BW'(MAX_DATA_BURST));
            end else if (dm_req) begin
                w_grant    = 1'b1;
                w_grant_dm = 1'b1;
            end else if (if_req) begin
                w_grant    = 1'b1;
                w_grant_dm = 1'b0;
            end else begin
                w_grant    = 1'b0;
                w_grant_dm = 1'b0;
            end
        end else begin
            w_grant    = 1'b0;
            w_grant_dm = 1'b0;
        end
    end

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_err       <= 1'b0;
            r_burst_cnt <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_mem_we    <= w_grant_dm & dm_we;
                        r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
                        r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
                        r_mem_req   <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_state     <= BUSY;
                        // Burst only accumulates while fetch is actually being held off.
                        if (!w_grant_dm || !if_req) begin
                            r_burst_cnt <= '0;
                        end else if (r_burst_cnt != BW'(MAX_DATA_BURST)) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        r_err     <= r_err | ~mem_ack;
                        if (r_owner == OWN_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= mem_ack ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
                        end else begin
                            r_dm_ready <= 1'b1;
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_ack ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
                            end
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_if_ready <= 1'b0;
                    r_dm_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_mem_req  <= 1'b0;
                    r_if_ready <= 1'b0;
                    r_dm_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign err       = r_err;

endmodule
